dmem_arbiter: RTL and testbench

Data-memory access controller sitting in front of the single-ported data memory, between the EX/MEM pipeline register and the MEM stage. It arbitrates the memory between the CPU pipeline and an external loader/debug port, sequences fixed-latency reads, and stalls the pipeline while a CPU read is in flight. Read data it returns is what the MEM stage forwards to writeback as mem_out.

---
 rtl/dmem_pkg.sv | 24 ++
 rtl/dmem_arbiter_if.sv | 48 ++++
 rtl/dmem_starve_ctr.sv | 30 +++
 rtl/dmem_arbiter.sv | 120 ++++++++++++
 tb/tb_dmem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter: FSM states, read owner, and the
// request bundle used to pick the winning master. Also used by the hazard unit.
package dmem_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } dmem_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_EXT = 1'b1
  } dmem_owner_e;

  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// CPU, external-port and memory-side signals of the data-memory arbiter.
// slave = arbiter view; master = the surrounding pipeline/loader/memory.
interface dmem_arbiter_if
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 14
);
  logic              cpu_req;
  logic              cpu_we;
  logic [XLEN-1:0]   cpu_addr;
  logic [XLEN-1:0]   cpu_wdata;
  logic              cpu_stall;
  logic              cpu_rvalid;
  logic [XLEN-1:0]   cpu_rdata;

  logic              ext_req;
  logic              ext_we;
  logic [XLEN-1:0]   ext_addr;
  logic [XLEN-1:0]   ext_wdata;
  logic              ext_gnt;
  logic              ext_rvalid;
  logic [XLEN-1:0]   ext_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN-1:0]   mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rvalid, cpu_rdata,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    output ext_gnt, ext_rvalid, ext_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rvalid, cpu_rdata,
    output ext_req, ext_we, ext_addr, ext_wdata,
    input  ext_gnt, ext_rvalid, ext_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_starve_ctr.sv
// Saturating count of cycles the external port has waited; at_max forces
// the next IDLE arbitration in favour of the external master.
module dmem_starve_ctr #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = $clog2(MAX_WAIT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  logic [CNT_W-1:0] cnt_q;

  assign at_max = (cnt_q == CNT_W'(MAX_WAIT));

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && !at_max) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory access controller: arbitrates the single-ported memory between
// the CPU pipeline and the external port, sequences fixed-latency reads.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int RD_LAT   = 2,
  parameter int ADDR_W   = 14,
  parameter int MAX_WAIT = 4
) (
  input logic           clk,
  input logic           rst_n,
  dmem_arbiter_if.slave bus
);

  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  dmem_state_e     state_q, state_d;
  dmem_owner_e     owner_q, owner_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [XLEN-1:0] cpu_rdata_q, ext_rdata_q;

  dmem_req_t cpu_r, ext_r, sel;
  logic      mem_en, ext_win, ext_gnt, cpu_wr_gnt, capture;
  logic      cpu_rvalid, ext_rvalid, starve_max;
  logic      addr_unused;

  assign cpu_r   = '{we: bus.cpu_we, addr: bus.cpu_addr, wdata: bus.cpu_wdata};
  assign ext_r   = '{we: bus.ext_we, addr: bus.ext_addr, wdata: bus.ext_wdata};
  assign ext_win = bus.ext_req & (~bus.cpu_req | starve_max);

  dmem_starve_ctr #(
    .MAX_WAIT(MAX_WAIT)
  ) u_starve (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (bus.ext_req & ~ext_gnt),
    .clr   (ext_gnt),
    .at_max(starve_max)
  );

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    lat_d      = lat_q;
    sel        = '0;
    mem_en     = 1'b0;
    ext_gnt    = 1'b0;
    cpu_wr_gnt = 1'b0;
    capture    = 1'b0;
    cpu_rvalid = 1'b0;
    ext_rvalid = 1'b0;
    // Outputs must read 0 while reset is held, even with requests pending.
    if (rst_n) begin
      case (state_q)
        IDLE: begin
          if (bus.cpu_req | bus.ext_req) begin
            sel        = ext_win ? ext_r : cpu_r;
            mem_en     = 1'b1;
            ext_gnt    = ext_win;
            cpu_wr_gnt = ~ext_win & cpu_r.we;
            if (!sel.we) begin
              owner_d = ext_win ? OWN_EXT : OWN_CPU;
              lat_d   = LAT_W'(RD_LAT - 1);
              state_d = RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (lat_q == '0) begin
            capture = 1'b1;
            state_d = RESP;
          end else begin
            lat_d = lat_q - LAT_W'(1);
          end
        end
        RESP: begin
          cpu_rvalid = (owner_q == OWN_CPU);
          ext_rvalid = (owner_q == OWN_EXT);
          state_d    = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_CPU;
      lat_q       <= '0;
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      lat_q   <= lat_d;
      if (capture) begin
        if (owner_q == OWN_CPU) cpu_rdata_q <= bus.mem_rdata;
        else                    ext_rdata_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_en     = mem_en;
  assign bus.mem_we     = sel.we;
  assign bus.mem_addr   = sel.addr[ADDR_W+1:2];
  assign bus.mem_wdata  = sel.wdata;
  assign bus.ext_gnt    = ext_gnt;
  assign bus.cpu_rvalid = cpu_rvalid;
  assign bus.ext_rvalid = ext_rvalid;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.ext_rdata  = ext_rdata_q;
  assign bus.cpu_stall  = rst_n & bus.cpu_req & ~(cpu_wr_gnt | cpu_rvalid);

  // Byte-offset and above-window address bits are dropped by design.
  assign addr_unused = ^{sel.addr[1:0], sel.addr[XLEN-1:ADDR_W+2]};

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, multi-cycle
// sequences, latency variants, and random traffic against a cycle-count model.
module tb_dmem_arbiter;

  localparam int RD_LAT   = 2;
  localparam int ADDR_W   = 14;
  localparam int MAX_WAIT = 4;
  localparam int DEPTH    = 1 << ADDR_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  dmem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();
  dmem_arbiter_if #(.ADDR_W(ADDR_W)) l1_bus ();
  dmem_arbiter_if #(.ADDR_W(ADDR_W)) l4_bus ();

  dmem_arbiter #(.RD_LAT(RD_LAT), .ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  dmem_arbiter #(.RD_LAT(1), .ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT))
    dut_l1 (.clk(clk), .rst_n(rst_n), .bus(l1_bus));
  dmem_arbiter #(.RD_LAT(4), .ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT))
    dut_l4 (.clk(clk), .rst_n(rst_n), .bus(l4_bus));

  // Latency variants: one CPU read port each, memory returns the cycle number
  // so the captured value reveals the capture cycle.
  logic lat_req = 1'b0;
  assign l1_bus.cpu_req = lat_req;   assign l4_bus.cpu_req = lat_req;
  assign l1_bus.cpu_we = 1'b0;       assign l4_bus.cpu_we = 1'b0;
  assign l1_bus.cpu_addr = 32'h40;   assign l4_bus.cpu_addr = 32'h40;
  assign l1_bus.cpu_wdata = '0;      assign l4_bus.cpu_wdata = '0;
  assign l1_bus.ext_req = 1'b0;      assign l4_bus.ext_req = 1'b0;
  assign l1_bus.ext_we = 1'b0;       assign l4_bus.ext_we = 1'b0;
  assign l1_bus.ext_addr = '0;       assign l4_bus.ext_addr = '0;
  assign l1_bus.ext_wdata = '0;      assign l4_bus.ext_wdata = '0;
  assign l1_bus.mem_rdata = 32'(cyc); assign l4_bus.mem_rdata = 32'(cyc);

  // Physical memory seen by the main DUT: writes land at the edge, reads
  // return data exactly RD_LAT cycles after issue, garbage otherwise.
  logic [31:0]       tb_mem  [DEPTH];
  logic [31:0]       ref_mem [DEPTH];
  logic              mem_ready = 1'b0;
  logic [RD_LAT-1:0] rd_v = '0;
  logic [ADDR_W-1:0] rd_a [RD_LAT];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!mem_ready) begin
      for (int i = 0; i < DEPTH; i++) tb_mem[i] <= 32'hC0DE_0000 | 32'(i);
      mem_ready <= 1'b1;
    end else if (bus.mem_en && bus.mem_we) begin
      tb_mem[bus.mem_addr] <= bus.mem_wdata;
    end
    rd_v[0] <= bus.mem_en & ~bus.mem_we;
    rd_a[0] <= bus.mem_addr;
    for (int i = 1; i < RD_LAT; i++) begin
      rd_v[i] <= rd_v[i-1];
      rd_a[i] <= rd_a[i-1];
    end
  end
  assign bus.mem_rdata = rd_v[RD_LAT-1] ? tb_mem[rd_a[RD_LAT-1]] : 32'hBAD0_BAD0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask

  task automatic set_ext(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
    bus.ext_req = req; bus.ext_we = we; bus.ext_addr = a; bus.ext_wdata = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_cpu(0, 0, 0, 0);
    set_ext(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rnd_addr();
    return ($urandom() & 32'hFFFF_0000) | (32'($urandom_range(0, 15)) << 2) |
           32'($urandom_range(0, 3));
  endfunction

  typedef struct {
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        ext_req, ext_we;
    logic [31:0] ext_addr, ext_wdata;
    logic        en, we;
    logic [13:0] addr;
    logic [31:0] wdata;
    logic        stall, gnt;
  } vec_t;

  vec_t vecs [10];

  // Reference model state, in terms of cycle numbers rather than FSM states.
  bit          m_busy, m_own_cpu, ext_wins, cpu_wr, e_gnt_prev;
  int          m_resp, m_starve, m_cyc;
  logic [31:0] m_data, m_cpu_rdata, m_ext_rdata;

  initial begin
    logic [31:0] c0, l1_d, l4_d, sel_a, sel_d;
    int          l1_at, l4_at;
    logic        sel_we, e_en, e_we, e_gnt, e_cv, e_ev, e_stall;
    logic [13:0] idx;

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'hC0DE_0000 | 32'(i);
    set_cpu(0, 0, 0, 0);
    set_ext(0, 0, 0, 0);
    #2;
    check("rst_stall", 32'(bus.cpu_stall), 0);
    check("rst_en", 32'(bus.mem_en), 0);
    check("rst_gnt", 32'(bus.ext_gnt), 0);
    check("rst_cpu_rdata", bus.cpu_rdata, 0);
    do_reset();

    vecs[0] = '{0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 14'h0, 32'h0, 0, 0};
    vecs[1] = '{1, 1, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0, 32'h0, 1, 1, 14'h40, 32'hDEADBEEF, 0, 0};
    vecs[2] = '{0, 0, 32'h0, 32'h0, 1, 1, 32'h200, 32'h12345678, 1, 1, 14'h80, 32'h12345678, 0, 1};
    vecs[3] = '{1, 1, 32'hFFFF0104, 32'hA5A5A5A5, 1, 1, 32'h300, 32'h0BADF00D, 1, 1, 14'h41, 32'hA5A5A5A5, 0, 0};
    vecs[4] = '{1, 1, 32'h10B, 32'h11111111, 1, 1, 32'h300, 32'h0BADF00D, 1, 1, 14'h42, 32'h11111111, 0, 0};
    vecs[5] = '{1, 1, 32'h10C, 32'h22222222, 1, 1, 32'h300, 32'h0BADF00D, 1, 1, 14'h43, 32'h22222222, 0, 0};
    vecs[6] = '{1, 1, 32'h110, 32'h33333333, 1, 1, 32'h300, 32'h0BADF00D, 1, 1, 14'h44, 32'h33333333, 0, 0};
    vecs[7] = '{1, 1, 32'h114, 32'h44444444, 1, 1, 32'h300, 32'h0BADF00D, 1, 1, 14'hC0, 32'h0BADF00D, 1, 1};
    vecs[8] = '{1, 1, 32'h114, 32'h44444444, 0, 0, 32'h0, 32'h0, 1, 1, 14'h45, 32'h44444444, 0, 0};
    vecs[9] = '{0, 1, 32'h118, 32'h55555555, 0, 0, 32'h0, 32'h0, 0, 0, 14'h0, 32'h0, 0, 0};

    for (int v = 0; v < 10; v++) begin
      next_cycle();
      set_cpu(vecs[v].cpu_req, vecs[v].cpu_we, vecs[v].cpu_addr, vecs[v].cpu_wdata);
      set_ext(vecs[v].ext_req, vecs[v].ext_we, vecs[v].ext_addr, vecs[v].ext_wdata);
      #1;
      check($sformatf("vec%0d_en", v), 32'(bus.mem_en), 32'(vecs[v].en));
      check($sformatf("vec%0d_gnt", v), 32'(bus.ext_gnt), 32'(vecs[v].gnt));
      check($sformatf("vec%0d_stall", v), 32'(bus.cpu_stall), 32'(vecs[v].stall));
      if (vecs[v].en) begin
        check($sformatf("vec%0d_we", v), 32'(bus.mem_we), 32'(vecs[v].we));
        check($sformatf("vec%0d_addr", v), 32'(bus.mem_addr), 32'(vecs[v].addr));
        check($sformatf("vec%0d_wdata", v), bus.mem_wdata, vecs[v].wdata);
        if (vecs[v].we) ref_mem[vecs[v].addr] = vecs[v].wdata;
      end
    end

    // CPU read of 0x100: stall for issue + RD_LAT cycles, data the cycle after.
    next_cycle(); set_cpu(1, 0, 32'h100, 0); set_ext(0, 0, 0, 0); #1;
    check("rd_issue_en", 32'(bus.mem_en), 1);
    check("rd_issue_we", 32'(bus.mem_we), 0);
    check("rd_issue_addr", 32'(bus.mem_addr), 32'h40);
    check("rd_issue_stall", 32'(bus.cpu_stall), 1);
    next_cycle(); #1;
    check("rd_w1_stall", 32'(bus.cpu_stall), 1);
    check("rd_w1_en", 32'(bus.mem_en), 0);
    check("rd_w1_rvalid", 32'(bus.cpu_rvalid), 0);
    next_cycle(); #1;
    check("rd_w2_stall", 32'(bus.cpu_stall), 1);
    check("rd_w2_rvalid", 32'(bus.cpu_rvalid), 0);
    next_cycle(); #1;
    check("rd_resp_stall", 32'(bus.cpu_stall), 0);
    check("rd_resp_rvalid", 32'(bus.cpu_rvalid), 1);
    check("rd_resp_data", bus.cpu_rdata, 32'hDEADBEEF);
    check("rd_resp_en", 32'(bus.mem_en), 0);
    next_cycle(); set_cpu(0, 0, 0, 0); #1;
    check("rd_after_rvalid", 32'(bus.cpu_rvalid), 0);

    // Flushed read: request drops after issue, response still pulses.
    next_cycle(); set_cpu(1, 0, 32'h104, 0); #1;
    check("fl_issue_en", 32'(bus.mem_en), 1);
    next_cycle(); set_cpu(0, 0, 0, 0); #1;
    check("fl_stall", 32'(bus.cpu_stall), 0);
    next_cycle(); #1;
    next_cycle(); #1;
    check("fl_rvalid", 32'(bus.cpu_rvalid), 1);
    check("fl_data", bus.cpu_rdata, 32'hA5A5A5A5);
    next_cycle(); #1;
    check("fl_after_rvalid", 32'(bus.cpu_rvalid), 0);

    // External read while the CPU waits with a write behind it.
    next_cycle(); set_ext(1, 0, 32'h200, 0); #1;
    check("er_gnt", 32'(bus.ext_gnt), 1);
    check("er_addr", 32'(bus.mem_addr), 32'h80);
    next_cycle(); set_ext(0, 0, 0, 0); set_cpu(1, 1, 32'h120, 32'h77); #1;
    check("er_w1_stall", 32'(bus.cpu_stall), 1);
    check("er_w1_gnt", 32'(bus.ext_gnt), 0);
    check("er_w1_en", 32'(bus.mem_en), 0);
    next_cycle(); #1;
    check("er_w2_stall", 32'(bus.cpu_stall), 1);
    next_cycle(); #1;
    check("er_resp_ext_rvalid", 32'(bus.ext_rvalid), 1);
    check("er_resp_ext_rdata", bus.ext_rdata, 32'h12345678);
    check("er_resp_cpu_rvalid", 32'(bus.cpu_rvalid), 0);
    check("er_resp_stall", 32'(bus.cpu_stall), 1);
    next_cycle(); #1;
    check("er_cpu_wr_stall", 32'(bus.cpu_stall), 0);
    check("er_cpu_wr_addr", 32'(bus.mem_addr), 32'h48);
    ref_mem[14'h48] = 32'h77;
    next_cycle(); set_cpu(0, 0, 0, 0); #1;

    // Reset mid-read: outputs clear immediately, no response afterwards.
    set_cpu(1, 0, 32'h100, 0); #1;
    next_cycle(); #2;
    rst_n = 1'b0; #1;
    check("mr_stall", 32'(bus.cpu_stall), 0);
    check("mr_en", 32'(bus.mem_en), 0);
    check("mr_we", 32'(bus.mem_we), 0);
    check("mr_addr", 32'(bus.mem_addr), 0);
    check("mr_wdata", bus.mem_wdata, 0);
    check("mr_gnt", 32'(bus.ext_gnt), 0);
    check("mr_cpu_rvalid", 32'(bus.cpu_rvalid), 0);
    check("mr_ext_rvalid", 32'(bus.ext_rvalid), 0);
    check("mr_cpu_rdata", bus.cpu_rdata, 0);
    check("mr_ext_rdata", bus.ext_rdata, 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    set_cpu(0, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      next_cycle(); #1;
      check($sformatf("mr_post%0d_rvalid", k), 32'(bus.cpu_rvalid), 0);
    end

    // Latency variants: RD_LAT=1 responds at T+2, RD_LAT=4 at T+5.
    next_cycle(); lat_req = 1'b1; c0 = 32'(cyc);
    l1_at = -1; l4_at = -1; l1_d = '0; l4_d = '0;
    for (int k = 1; k <= 8; k++) begin
      next_cycle(); lat_req = 1'b0; #1;
      if (l1_bus.cpu_rvalid && l1_at < 0) begin l1_at = k; l1_d = l1_bus.cpu_rdata; end
      if (l4_bus.cpu_rvalid && l4_at < 0) begin l4_at = k; l4_d = l4_bus.cpu_rdata; end
    end
    check("lat1_cycle", 32'(l1_at), 2);
    check("lat1_data", l1_d, c0 + 1);
    check("lat4_cycle", 32'(l4_at), 5);
    check("lat4_data", l4_d, c0 + 4);

    // Random traffic against the reference model.
    do_reset();
    m_busy = 0; m_starve = 0; m_cyc = 0; m_resp = 0; m_own_cpu = 0;
    m_data = '0; m_cpu_rdata = '0; m_ext_rdata = '0; e_gnt_prev = 0;
    for (int n = 0; n < 2000; n++) begin
      next_cycle();
      set_cpu($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), rnd_addr(), $urandom());
      if (!(bus.ext_req && !e_gnt_prev))
        set_ext($urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)), rnd_addr(), $urandom());
      #1;
      e_en = 0; e_we = 0; e_gnt = 0; e_cv = 0; e_ev = 0; cpu_wr = 0;
      sel_a = '0; sel_d = '0; idx = '0;
      if (m_busy) begin
        if (m_cyc == m_resp) begin
          if (m_own_cpu) begin e_cv = 1; m_cpu_rdata = m_data; end
          else           begin e_ev = 1; m_ext_rdata = m_data; end
          m_busy = 0;
        end
      end else if (bus.cpu_req || bus.ext_req) begin
        ext_wins = bus.ext_req && (!bus.cpu_req || m_starve == MAX_WAIT);
        sel_we = ext_wins ? bus.ext_we : bus.cpu_we;
        sel_a  = ext_wins ? bus.ext_addr : bus.cpu_addr;
        sel_d  = ext_wins ? bus.ext_wdata : bus.cpu_wdata;
        idx    = sel_a[ADDR_W+1:2];
        e_en = 1; e_we = sel_we; e_gnt = ext_wins;
        cpu_wr = !ext_wins && sel_we;
        if (sel_we) ref_mem[idx] = sel_d;
        else begin
          m_busy = 1; m_resp = m_cyc + RD_LAT + 1;
          m_own_cpu = !ext_wins; m_data = ref_mem[idx];
        end
      end
      e_stall = bus.cpu_req && !(cpu_wr || e_cv);
      check("rnd_en", 32'(bus.mem_en), 32'(e_en));
      check("rnd_gnt", 32'(bus.ext_gnt), 32'(e_gnt));
      check("rnd_stall", 32'(bus.cpu_stall), 32'(e_stall));
      check("rnd_cpu_rvalid", 32'(bus.cpu_rvalid), 32'(e_cv));
      check("rnd_ext_rvalid", 32'(bus.ext_rvalid), 32'(e_ev));
      check("rnd_cpu_rdata", bus.cpu_rdata, m_cpu_rdata);
      check("rnd_ext_rdata", bus.ext_rdata, m_ext_rdata);
      if (e_en) begin
        check("rnd_we", 32'(bus.mem_we), 32'(e_we));
        check("rnd_addr", 32'(bus.mem_addr), 32'(idx));
        check("rnd_wdata", bus.mem_wdata, sel_d);
      end
      if (e_gnt) m_starve = 0;
      else if (bus.ext_req && m_starve < MAX_WAIT) m_starve++;
      e_gnt_prev = e_gnt;
      m_cyc++;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
